// File: rtl/operand_driver.sv
// Operand driver: 3-stage operand pipeline with bit masks, monitor delay line,
// and a marker-based FSM that measures the latency of the attached DUT.
module operand_driver #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_OPS   = 2,
    parameter int unsigned K       = 8,
    parameter int unsigned MON_LAT = 2
) (
    input  logic                     clk_dut,
    input  logic                     reset,
    input  logic [N_OPS*WIDTH-1:0]   i_rand,
    input  logic [WIDTH-1:0]         i_dut_out,
    input  logic                     i_fselect,
    input  logic [N_OPS*WIDTH-1:0]   i_fmanual,
    input  logic [N_OPS*WIDTH-1:0]   i_fbitset,
    input  logic [N_OPS*WIDTH-1:0]   i_fbitclr,
    input  logic                     i_remeasure,
    output logic [31:0]              o_dut_delay,
    output logic                     o_delay_valid,
    output logic                     o_timeout,
    output logic [N_OPS*WIDTH-1:0]   o_drive_dut,
    output logic [N_OPS*WIDTH-1:0]   o_drive_mon
);

    localparam int unsigned BUS_W   = N_OPS * WIDTH;
    localparam logic [K-1:0] CNT_MAX = '1;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_FLUSH   = 6'b000010,
        S_INJECT  = 6'b000100,
        S_COUNT   = 6'b001000,
        S_DONE    = 6'b010000,
        S_TIMEOUT = 6'b100000
    } state_t;

    state_t           state_q, state_d;
    logic [K-1:0]     flush_cnt_q, flush_cnt_d;
    logic [K-1:0]     delay_cnt_q, delay_cnt_d;
    logic [K-1:0]     lat_q, lat_d;
    logic             armed_q, armed_d;
    logic [31:0]      dut_delay_q, dut_delay_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [BUS_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic             mask_byp;

    // Delay-measurement FSM next state, counters and registered status outputs
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        delay_cnt_d = delay_cnt_q;
        lat_d       = lat_q;
        armed_d     = armed_q;
        case (state_q)
            S_IDLE: begin
                flush_cnt_d = '0;
                delay_cnt_d = '0;
                armed_d     = 1'b0;
                if (!i_fselect) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == CNT_MAX && i_dut_out != '0) state_d = S_INJECT;
            end
            S_INJECT: state_d = S_COUNT;
            S_COUNT: begin
                // marker is being loaded into stage 3 on this edge: count starts at 0
                if (tag2_q) begin
                    delay_cnt_d = '0;
                end else if (armed_q || tag3_q) begin
                    armed_d = 1'b1;
                    if (i_dut_out == '0) begin
                        lat_d   = delay_cnt_q;
                        state_d = S_DONE;
                    end else if (delay_cnt_q == CNT_MAX) begin
                        state_d = S_TIMEOUT;
                    end else begin
                        delay_cnt_d = delay_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE, S_TIMEOUT: begin
                if (i_remeasure) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_fselect && state_q != S_DONE && state_q != S_TIMEOUT) state_d = S_IDLE;

        valid_d     = (state_d == S_DONE);
        timeout_d   = (state_d == S_TIMEOUT);
        dut_delay_d = valid_d ? 32'(lat_d) : 32'hFFFF_FFFF;
    end

    // Operand pipeline: source select, set mask, clear mask; markers carry a bypass tag
    always_comb begin
        mask_byp = i_fselect || state_q == S_FLUSH || state_q == S_INJECT || state_q == S_COUNT;
        if (i_fselect)               s1_d = i_fmanual;
        else if (state_q == S_INJECT) s1_d = '0;
        else                          s1_d = i_rand;
        tag1_d = (state_q == S_INJECT) && !i_fselect;
        s2_d   = (mask_byp || tag1_q) ? s1_q : (s1_q | i_fbitset);
        tag2_d = tag1_q;
        s3_d   = (mask_byp || tag2_q) ? s2_q : (s2_q & ~i_fbitclr);
        tag3_d = tag2_q;
    end

    // State, counter, pipeline and output registers
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            delay_cnt_q <= '0;
            lat_q       <= '0;
            armed_q     <= 1'b0;
            dut_delay_q <= 32'hFFFF_FFFF;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            tag1_q      <= 1'b0;
            tag2_q      <= 1'b0;
            tag3_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            lat_q       <= lat_d;
            armed_q     <= armed_d;
            dut_delay_q <= dut_delay_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            tag3_q      <= tag3_d;
        end
    end

    assign o_drive_dut   = s3_q;
    assign o_dut_delay   = dut_delay_q;
    assign o_delay_valid = valid_q;
    assign o_timeout     = timeout_q;

    // Monitor copy of the DUT operands, delayed by MON_LAT cycles
    if (MON_LAT == 0) begin : g_mon_comb
        assign o_drive_mon = s3_q;
    end else begin : g_mon_pipe
        logic [BUS_W-1:0] mon_q [MON_LAT];
        logic [BUS_W-1:0] mon_d [MON_LAT];

        // Shift-register next values
        always_comb begin
            mon_d[0] = s3_q;
            for (int unsigned i = 1; i < MON_LAT; i++) mon_d[i] = mon_q[i-1];
        end

        // Monitor delay registers
        always_ff @(posedge clk_dut or posedge reset) begin
            if (reset) begin
                for (int unsigned i = 0; i < MON_LAT; i++) mon_q[i] <= '0;
            end else begin
                mon_q <= mon_d;
            end
        end

        assign o_drive_mon = mon_q[MON_LAT-1];
    end

endmodule

// File: doc/operand_driver.md
OPERAND_DRIVER -- requirements
Module: operand_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter N_OPS, default 2, giving the operand count (1..8).
REQ-003 The block SHALL have parameter K, default 8, giving the delay/flush counter width (2..16).
REQ-004 The block SHALL have parameter MON_LAT, default 2, giving the extra monitor-path register stages (0..8).
REQ-005 The block SHALL have port clk_dut, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port i_rand, input, N_OPS*WIDTH bits: random operands, op k at bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port i_dut_out, input, WIDTH bits: the DUT result.
REQ-009 The block SHALL have port i_fselect, input, 1 bit: 1 = manual mode, 0 = random mode.
REQ-010 The block SHALL have ports i_fmanual, i_fbitset and i_fbitclr, each input, N_OPS*WIDTH bits: manual operands, set mask and clear mask.
REQ-011 The block SHALL have port i_remeasure, input, 1 bit: a pulse restarts the delay measurement.
REQ-012 The block SHALL have port o_dut_delay, output, 32 bits: the measured DUT latency.
REQ-013 The block SHALL have ports o_delay_valid and o_timeout, each output, 1 bit: measurement succeeded / failed.
REQ-014 The block SHALL have ports o_drive_dut and o_drive_mon, each output, N_OPS*WIDTH bits: operands to the DUT and to the monitor.

Function
REQ-015 The operand pipeline SHALL use 3 registered stages, and o_drive_dut SHALL be the stage-3 output, giving input-to-o_drive_dut latency of 3 cycles.
- Stage 1: source select: i_fmanual if i_fselect=1, marker zero if FSM in INJECT, otherwise i_rand.
- Stage 2: OR with i_fbitset.
- Stage 3: AND with ~i_fbitclr.
REQ-016 Stages 2 and 3 SHALL pass data unmodified in manual mode, for marker words, and while the FSM is in FLUSH, INJECT or COUNT; in these cases the masks are ignored.
REQ-017 Each marker word SHALL carry a 1-bit tag through the pipeline so that the bypass applies per word.
REQ-018 o_drive_mon SHALL equal o_drive_dut delayed by exactly MON_LAT cycles; for MON_LAT=0 it SHALL be a combinational copy.
REQ-019 The delay FSM SHALL have the states IDLE, FLUSH, INJECT, COUNT, DONE and TIMEOUT, one-hot encoded; any illegal encoding SHALL go to IDLE.
REQ-020 In IDLE, the block SHALL clear flush_cnt and delay_cnt, then go to FLUSH on the next edge if i_fselect=0.
REQ-021 In FLUSH, flush_cnt SHALL increment each cycle and saturate at 2^K-1; the FSM SHALL go to INJECT when flush_cnt is all-ones and i_dut_out != 0.
REQ-022 INJECT SHALL last exactly 1 cycle, then the FSM SHALL go to COUNT.
REQ-023 In COUNT, delay_cnt SHALL start at 0 on the edge at which the marker reaches o_drive_dut and increment once per cycle thereafter.
REQ-024 In COUNT, if i_dut_out==0 is sampled, the FSM SHALL go to DONE, latching delay_cnt so that a combinational DUT reports 0 and a DUT with D register stages reports D.
REQ-025 In COUNT, if delay_cnt reaches 2^K-1 with no zero sampled, the FSM SHALL go to TIMEOUT.
REQ-026 DONE and TIMEOUT SHALL be held until i_remeasure=1, which SHALL cause a transition to IDLE.
REQ-027 i_fselect=1 in any state other than DONE or TIMEOUT SHALL abort the measurement to IDLE on the next edge; the FSM SHALL stay in IDLE while i_fselect=1.
REQ-028 If i_remeasure=1 and i_fselect=1 occur together, the FSM SHALL go to IDLE and stay there.
REQ-029 o_dut_delay SHALL be the zero-extended latched count in DONE, and 32'hFFFF_FFFF otherwise.
REQ-030 o_delay_valid SHALL equal (state==DONE), and o_timeout SHALL equal (state==TIMEOUT).
REQ-031 All counters SHALL be exactly K bits wide with no wrap; they SHALL saturate or stop as stated above.

Reset
REQ-032 On reset assertion, the FSM SHALL go to IDLE, counters to 0, all pipeline and monitor registers to 0, o_dut_delay to all-ones, and o_delay_valid and o_timeout to 0, with effect immediate (asynchronous).
REQ-033 A reset asserted mid-measurement SHALL discard the measurement; a marker in flight SHALL be cleared along with its tag.
REQ-034 After reset deassertion, the block SHALL run the IDLE->FLUSH sequence automatically.

Verification
REQ-035 Bench SHALL cover: K=4, random mode, DUT = 3-stage register echo of op0, masks 0 -> DONE, o_dut_delay=3, o_delay_valid=1.
REQ-036 Bench SHALL cover: combinational DUT (i_dut_out=op0) -> o_dut_delay=0; set i_fbitset op0 = 32'h1 afterwards -> op0 bit0 =1 on o_drive_dut from 2 cycles later.
REQ-037 Bench SHALL cover: K=4, DUT = 20-stage delay -> o_timeout=1, o_dut_delay=32'hFFFF_FFFF; i_remeasure pulse -> FLUSH re-entered.
REQ-038 Bench SHALL cover: i_fbitset=all-ones during the measurement -> marker still zero at o_drive_dut, delay correct.
REQ-039 Bench SHALL cover: i_fselect=1 during COUNT -> IDLE next edge, o_drive_dut = i_fmanual after 3 cycles, o_drive_mon equals it MON_LAT cycles later.
REQ-040 Bench SHALL cover: reset asserted mid-COUNT -> all outputs at reset values immediately, without waiting for a clock edge.
